// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch queue between IF1 and decode.
// Circular buffer of fetch packets with first-word fall-through head view,
// per-slot validity derived from PC alignment and fetch exception, and flush.
module fetch_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     if1_valid,
  output logic                     fifo_ready,
  input  logic [31:0]              if1_pc,
  input  logic [31:0]              if1_inst0,
  input  logic [31:0]              if1_inst1,
  input  logic [31:0]              if1_badv,
  input  logic [6:0]               if1_exception,
  input  logic [1:0]               if1_excp_flag,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [31:0]              id_pc0,
  output logic [31:0]              id_pc1,
  output logic [31:0]              id_inst0,
  output logic [31:0]              id_inst1,
  output logic                     id_inst0_valid,
  output logic                     id_inst1_valid,
  output logic [31:0]              id_badv,
  output logic [6:0]               id_exception,
  output logic [1:0]               id_excp_flag,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0] r_pc   [DEPTH];
  logic [31:0] r_inst0[DEPTH];
  logic [31:0] r_inst1[DEPTH];
  logic [31:0] r_badv [DEPTH];
  logic [6:0]  r_exc  [DEPTH];
  logic [1:0]  r_flag [DEPTH];

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_head_pc;
  logic [6:0]    w_head_exc;
  logic [1:0]    w_slot_vld;

  // Slot validity {inst1_valid, inst0_valid}: an odd-word PC skips slot 0;
  // an excepting fetch exposes only the slot the PC points at.
  function automatic logic [1:0] slot_valid(input logic vld, input logic [6:0] exc,
                                            input logic odd);
    if (!vld)
      return 2'b00;
    if (exc == 7'd0)
      return {1'b1, ~odd};
    return {odd, ~odd};
  endfunction

  assign fifo_ready = (r_count != CW'(DEPTH));
  assign id_valid   = (r_count != '0);
  assign fifo_count = r_count;
  assign w_push     = if1_valid & fifo_ready;
  assign w_pop      = id_valid & id_ready;

  // Packet storage: written at the write pointer on an accepted push.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_inst0[i] <= '0;
        r_inst1[i] <= '0;
        r_badv[i]  <= '0;
        r_exc[i]   <= '0;
        r_flag[i]  <= '0;
      end
    end else if (w_push && !flush) begin
      r_pc[r_wptr]    <= if1_pc;
      r_inst0[r_wptr] <= if1_inst0;
      r_inst1[r_wptr] <= if1_inst1;
      r_badv[r_wptr]  <= if1_badv;
      r_exc[r_wptr]   <= if1_exception;
      r_flag[r_wptr]  <= if1_excp_flag;
    end
  end

  // Pointers and occupancy; flush overrides any same-cycle push or pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;
    end
  end

  assign w_head_pc  = r_pc[r_rptr];
  assign w_head_exc = r_exc[r_rptr];
  assign w_slot_vld = slot_valid(id_valid, w_head_exc, w_head_pc[2]);

  assign id_pc0         = {w_head_pc[31:3], 3'b000};
  assign id_pc1         = {w_head_pc[31:3], 3'b100};
  assign id_inst0       = r_inst0[r_rptr];
  assign id_inst1       = r_inst1[r_rptr];
  assign id_badv        = r_badv[r_rptr];
  assign id_exception   = w_head_exc;
  assign id_excp_flag   = r_flag[r_rptr];
  assign id_inst0_valid = w_slot_vld[0];
  assign id_inst1_valid = w_slot_vld[1];

endmodule

// File: tb/tb_fetch_buffer.sv
// Testbench for fetch_buffer: queue-based reference model plus scoreboard monitor.
module tb_fetch_buffer;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        if1_valid;
  logic        fifo_ready;
  logic [31:0] if1_pc, if1_inst0, if1_inst1, if1_badv;
  logic [6:0]  if1_exception;
  logic [1:0]  if1_excp_flag;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc0, id_pc1, id_inst0, id_inst1, id_badv;
  logic        id_inst0_valid, id_inst1_valid;
  logic [6:0]  id_exception;
  logic [1:0]  id_excp_flag;
  logic [3:0]  fifo_count;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .if1_valid(if1_valid),
    .fifo_ready(fifo_ready), .if1_pc(if1_pc), .if1_inst0(if1_inst0),
    .if1_inst1(if1_inst1), .if1_badv(if1_badv), .if1_exception(if1_exception),
    .if1_excp_flag(if1_excp_flag), .id_ready(id_ready), .id_valid(id_valid),
    .id_pc0(id_pc0), .id_pc1(id_pc1), .id_inst0(id_inst0), .id_inst1(id_inst1),
    .id_inst0_valid(id_inst0_valid), .id_inst1_valid(id_inst1_valid),
    .id_badv(id_badv), .id_exception(id_exception), .id_excp_flag(id_excp_flag),
    .fifo_count(fifo_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] badv;
    logic [6:0]  exc;
    logic [1:0]  flg;
  } pkt_t;

  pkt_t q[$];
  int   exp_cnt;
  int   errors;
  int   checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy and accepted packets, updated at each active edge.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_cnt = 0;
      q.delete();
    end else if (flush) begin
      exp_cnt = 0;
      q.delete();
    end else begin
      automatic int  n  = exp_cnt;
      automatic logic pu = if1_valid && (n < DEPTH);
      automatic logic po = id_ready && (n > 0);
      if (pu) begin
        automatic pkt_t p;
        p.pc = if1_pc; p.i0 = if1_inst0; p.i1 = if1_inst1;
        p.badv = if1_badv; p.exc = if1_exception; p.flg = if1_excp_flag;
        q.push_back(p);
      end
      exp_cnt = n + (pu ? 1 : 0) - (po ? 1 : 0);
    end
  end

  // Monitor: compare the presented head against the oldest expected packet.
  always @(negedge clk) begin
    chk("fifo_count", 32'(fifo_count), 32'(exp_cnt));
    chk("fifo_ready", 32'(fifo_ready), 32'(exp_cnt != DEPTH));
    chk("id_valid",   32'(id_valid),   32'(exp_cnt != 0));
    if (exp_cnt != 0) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty: got count %0d expected a queued packet", exp_cnt);
      end else begin
        automatic pkt_t p = q[0];
        automatic logic odd = p.pc[2];
        automatic logic ev0 = !odd;
        automatic logic ev1 = (p.exc == 7'd0) ? 1'b1 : odd;
        chk("id_pc0",       id_pc0, {p.pc[31:3], 3'b000});
        chk("id_pc1",       id_pc1, p.pc - (p.pc % 8) + 4);
        chk("id_inst0",     id_inst0, p.i0);
        chk("id_inst1",     id_inst1, p.i1);
        chk("id_badv",      id_badv, p.badv);
        chk("id_exception", 32'(id_exception), 32'(p.exc));
        chk("id_excp_flag", 32'(id_excp_flag), 32'(p.flg));
        chk("id_inst0_valid", 32'(id_inst0_valid), 32'(ev0));
        chk("id_inst1_valid", 32'(id_inst1_valid), 32'(ev1));
        if (id_ready) void'(q.pop_front());
      end
    end else begin
      chk("empty_slot0_valid", 32'(id_inst0_valid), 32'd0);
      chk("empty_slot1_valid", 32'(id_inst1_valid), 32'd0);
    end
  end

  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] i0,
                     input logic [31:0] i1, input logic [31:0] bv, input logic [6:0] ex,
                     input logic [1:0] fg, input logic rdy, input logic fl);
    if1_valid = v; if1_pc = pc; if1_inst0 = i0; if1_inst1 = i1;
    if1_badv = bv; if1_exception = ex; if1_excp_flag = fg;
    id_ready = rdy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] pc, input logic [6:0] ex, input logic [31:0] bv);
    cyc(1'b1, pc, pc ^ 32'h1111_0000, pc ^ 32'h2222_0000, bv, ex, 2'b01, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 7'h0, 2'b00, rdy, 1'b0);
  endtask

  initial begin
    errors = 0; checks = 0; exp_cnt = 0;
    rstn = 1'b0; flush = 1'b0; if1_valid = 1'b0; id_ready = 1'b0;
    if1_pc = '0; if1_inst0 = '0; if1_inst1 = '0; if1_badv = '0;
    if1_exception = '0; if1_excp_flag = '0;
    #22;
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_fifo_ready", 32'(fifo_ready), 32'd1);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_pc0", id_pc0, 32'd0);
    chk("rst_inst0", id_inst0, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Aligned packet, no exception.
    cyc(1'b1, 32'h1c00_0000, 32'h11, 32'h22, 32'h0, 7'h0, 2'b00, 1'b0, 1'b0);
    chk("t1_valid", 32'(id_valid), 32'd1);
    chk("t1_pc0", id_pc0, 32'h1c00_0000);
    chk("t1_pc1", id_pc1, 32'h1c00_0004);
    chk("t1_inst0", id_inst0, 32'h11);
    chk("t1_inst1", id_inst1, 32'h22);
    chk("t1_v0", 32'(id_inst0_valid), 32'd1);
    chk("t1_v1", 32'(id_inst1_valid), 32'd1);
    chk("t1_count", 32'(fifo_count), 32'd1);
    idle(1'b1);

    // Odd-word target.
    push1(32'h1c00_0004, 7'h0, 32'h0);
    chk("t2_v0", 32'(id_inst0_valid), 32'd0);
    chk("t2_v1", 32'(id_inst1_valid), 32'd1);
    chk("t2_pc1", id_pc1, 32'h1c00_0004);
    idle(1'b1);

    // Excepting fetches, even then odd word.
    push1(32'h1c00_0010, 7'h08, 32'h1c00_0010);
    chk("t3_v0", 32'(id_inst0_valid), 32'd1);
    chk("t3_v1", 32'(id_inst1_valid), 32'd0);
    chk("t3_exc", 32'(id_exception), 32'h08);
    chk("t3_badv", id_badv, 32'h1c00_0010);
    idle(1'b1);
    push1(32'h1c00_0014, 7'h08, 32'h1c00_0014);
    chk("t4_v0", 32'(id_inst0_valid), 32'd0);
    chk("t4_v1", 32'(id_inst1_valid), 32'd1);
    idle(1'b1);

    // Fill to full with decode stalled, ninth push must be ignored.
    for (int k = 0; k < DEPTH; k++) push1(32'(k * 8), 7'h0, 32'h0);
    chk("full_ready", 32'(fifo_ready), 32'd0);
    chk("full_count", 32'(fifo_count), 32'd8);
    push1(32'h40, 7'h0, 32'h0);
    chk("full_count_after9", 32'(fifo_count), 32'd8);
    for (int k = 0; k < DEPTH; k++) idle(1'b1);
    chk("drain_empty", 32'(id_valid), 32'd0);

    // Sustained push and pop at occupancy three.
    for (int k = 0; k < 3; k++) push1(32'h2000_0000 + 32'(k * 4), 7'h0, 32'h0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 32'h3000_0000 + 32'(k * 4), 32'(k), 32'(k + 100), 32'h0, 7'h0, 2'b10, 1'b1, 1'b0);
      chk("pp_count", 32'(fifo_count), 32'd3);
    end
    for (int k = 0; k < 3; k++) idle(1'b1);

    // Flush with a simultaneous push at occupancy five.
    for (int k = 0; k < 5; k++) push1(32'h4000_0000 + 32'(k * 8), 7'h0, 32'h0);
    cyc(1'b1, 32'hdead_0000, 32'hdead, 32'hbeef, 32'h0, 7'h0, 2'b00, 1'b0, 1'b1);
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_valid", 32'(id_valid), 32'd0);
    chk("flush_ready", 32'(fifo_ready), 32'd1);
    push1(32'h5000_0000, 7'h0, 32'h0);
    chk("after_flush_pc0", id_pc0, 32'h5000_0000);
    push1(32'h5000_0008, 7'h3, 32'h5000_0008);
    for (int k = 0; k < 3; k++) idle(1'b1);

    // Asynchronous reset mid-stream.
    for (int k = 0; k < 4; k++) push1(32'h6000_0000 + 32'(k * 8), 7'h0, 32'h0);
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", 32'(id_valid), 32'd0);
    chk("arst_ready", 32'(fifo_ready), 32'd1);
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_pc1", id_pc1, 32'h4);
    chk("arst_inst1", id_inst1, 32'd0);
    chk("arst_badv", id_badv, 32'd0);
    chk("arst_v1", 32'(id_inst1_valid), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      automatic logic [31:0] pc = $urandom;
      automatic logic [6:0]  ex = ($urandom_range(0, 1) == 0) ? 7'h0 : 7'($urandom_range(1, 127));
      cyc(1'($urandom_range(0, 3) != 0), pc, $urandom, $urandom, $urandom, ex,
          2'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end
    for (int k = 0; k < DEPTH + 2; k++) idle(1'b1);
    chk("final_empty", 32'(id_valid), 32'd0);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
